// File: rtl/ruler_search_sequencer.sv
// ruler_search_sequencer
//   Drives the mark_counter chain of a Golomb ruler search. It holds the single
//   'enabled' token, issues one counter step every two cycles, reads back the level
//   the active counter hands the token to, captures every complete ruler, tightens
//   'limit' so only strictly shorter rulers are accepted, and reports completion
//   once the token falls back to level 0.
//
//   State table
//     state   | meaning
//     IDLE    | waiting for start after reset
//     INIT    | counters reset, level 1 primed as nextEnabled
//     SETTLE  | waiting for every counter to report ready
//     STEP    | token level drives 'enabled' for exactly one cycle
//     COLLECT | reading the registered nextEnabled of the stepped counter
//     CAPTURE | a full ruler is present on marks_in; record it, shrink limit
//     DONE    | search finished (aborted tells exhausted budget/protocol error)
//
//   Ports
//     clock, reset          rising-edge clock, synchronous active-high reset
//     start, pause          search launch pulse; pause holds in COLLECT
//     max_length            initial limit, sampled with start
//     ctr_next_enabled      nextEnabled of the currently enabled counter
//     ctr_ready             all counters ready
//     marks_in              current positions {m0..mN}, m0 in the MSBs
//     ctr_reset, enabled    counter reset strobe and token level (7'h7F = none)
//     limit                 current length bound for all counters
//     busy, found, done     status; found pulses on each captured ruler
//     best_marks/length     last captured ruler and its last mark (0 = none)
//     aborted, step_count   abort flag in DONE and number of steps issued
module ruler_search_sequencer #(
  parameter int NUMPOSITIONS = 5,
  parameter int MAXVALUE     = 500,
  parameter int MAXSTEPS     = 2**24
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic [8:0]                    max_length,
  input  logic [6:0]                    ctr_next_enabled,
  input  logic                          ctr_ready,
  input  logic [(NUMPOSITIONS+1)*9-1:0] marks_in,
  output logic                          ctr_reset,
  output logic [6:0]                    enabled,
  output logic [8:0]                    limit,
  output logic                          busy,
  output logic                          found,
  output logic [(NUMPOSITIONS+1)*9-1:0] best_marks,
  output logic [8:0]                    best_length,
  output logic                          done,
  output logic                          aborted,
  output logic [23:0]                   step_count
);

  localparam int MW = (NUMPOSITIONS+1)*9;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_STEP    = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [6:0]  NO_LVL   = 7'h7F;
  localparam logic [6:0]  LAST_LVL = 7'(NUMPOSITIONS);
  localparam logic [6:0]  FULL_LVL = 7'(NUMPOSITIONS + 1);
  // Shortest possible ruler: marks 0,1,3,6,... cannot beat the triangular number.
  localparam logic [8:0]  MIN_LEN  = 9'(NUMPOSITIONS*(NUMPOSITIONS+1)/2);
  localparam logic [8:0]  MAX_LIM  = 9'(MAXVALUE);
  localparam logic [24:0] STEP_MAX = 25'(MAXSTEPS);

  logic [2:0]    state_q, state_d;
  logic [6:0]    token_q, token_d;
  logic [8:0]    limit_q, limit_d;
  logic [MW-1:0] best_marks_q, best_marks_d;
  logic [8:0]    best_length_q, best_length_d;
  logic          aborted_q, aborted_d;
  logic [24:0]   steps_q, steps_d;

  logic [8:0]    last_mark;
  logic          budget_spent;

  assign last_mark    = marks_in[8:0];
  assign budget_spent = (steps_q == STEP_MAX);

  always_comb begin
    state_d       = state_q;
    token_d       = token_q;
    limit_d       = limit_q;
    best_marks_d  = best_marks_q;
    best_length_d = best_length_q;
    aborted_d     = aborted_q;
    steps_d       = steps_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          limit_d       = (max_length > MAX_LIM) ? MAX_LIM : max_length;
          steps_d       = '0;
          best_length_d = '0;
          aborted_d     = 1'b0;
          token_d       = 7'd1;
          // Too short to hold any ruler: finish immediately with nothing found.
          state_d       = (max_length < MIN_LEN) ? S_DONE : S_INIT;
        end
      end
      S_INIT: state_d = S_SETTLE;
      S_SETTLE: begin
        if (ctr_ready) begin
          token_d = 7'd1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        steps_d = budget_spent ? steps_q : steps_q + 25'd1;
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (ctr_next_enabled == 7'd0) begin
          state_d = S_DONE;
        end else if (ctr_next_enabled == FULL_LVL) begin
          state_d = S_CAPTURE;
        end else if (ctr_next_enabled == NO_LVL) begin
          // No level reported yet; keep waiting on the counter.
          state_d = S_COLLECT;
        end else if (ctr_next_enabled > FULL_LVL) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          token_d = ctr_next_enabled;
          if (budget_spent) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else if (!pause) begin
            state_d = S_STEP;
          end
        end
      end
      S_CAPTURE: begin
        best_marks_d  = marks_in;
        best_length_d = last_mark;
        // last_mark >= MIN_LEN > 0 here, so the decrement cannot wrap.
        limit_d       = last_mark - 9'd1;
        token_d       = LAST_LVL;
        state_d       = (last_mark <= MIN_LEN) ? S_DONE : S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      token_q       <= 7'd1;
      limit_q       <= '0;
      best_marks_q  <= '0;
      best_length_q <= '0;
      aborted_q     <= 1'b0;
      steps_q       <= '0;
    end else begin
      state_q       <= state_d;
      token_q       <= token_d;
      limit_q       <= limit_d;
      best_marks_q  <= best_marks_d;
      best_length_q <= best_length_d;
      aborted_q     <= aborted_d;
      steps_q       <= steps_d;
    end
  end

  always_comb begin
    enabled = NO_LVL;
    if (state_q == S_INIT)      enabled = 7'd1;
    else if (state_q == S_STEP) enabled = token_q;
  end

  assign ctr_reset   = (state_q == S_INIT);
  assign busy        = (state_q == S_INIT) || (state_q == S_SETTLE) || (state_q == S_STEP) ||
                       (state_q == S_COLLECT) || (state_q == S_CAPTURE);
  assign found       = (state_q == S_CAPTURE);
  assign done        = (state_q == S_DONE);
  assign limit       = limit_q;
  assign best_marks  = best_marks_q;
  assign best_length = best_length_q;
  assign aborted     = aborted_q;
  // A full 2**24 budget does not fit the 24-bit port; show it as all ones.
  assign step_count  = steps_q[24] ? 24'hFF_FFFF : steps_q[23:0];

endmodule

// File: tb/tb_ruler_search_sequencer.sv
// Bench: two sequencers, each driving a behavioural mark_counter chain.
//   inst 0: NUMPOSITIONS=3, default step budget
//   inst 1: NUMPOSITIONS=4, MAXSTEPS=16
// The counter model steps the enabled level upward by one, backtracks when the
// mark exceeds limit, advances when all differences stay distinct, retries
// otherwise. It enumerates ascending, so for N=3/limit 10 it meets {0,1,3,7}
// before {0,1,4,6}.
module tb_ruler_search_sequencer;

  typedef int marks_t[8];
  typedef struct {
    int          kind;   // 0 = found, 1 = done
    logic [44:0] marks;
    int          len;
    bit          abrt;
    int          steps;  // -1: compare against bench step counter
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   abort_mode = 1'b0;

  logic [1:0]       start_w = '0;
  logic [1:0]       pause_w = '0;
  logic [1:0][8:0]  maxl_w  = '0;
  logic [1:0][6:0]  nxt_w;
  logic [1:0]       rdy_w;
  logic [1:0][44:0] marks_w;
  logic [1:0]       ctr_reset_w;
  logic [1:0][6:0]  enabled_w;
  logic [1:0][8:0]  limit_w;
  logic [1:0]       busy_w, found_w, done_w, aborted_w;
  logic [1:0][44:0] best_w;
  logic [1:0][8:0]  bestlen_w;
  logic [1:0][23:0] stepc_w;

  int n_checks = 0;
  int n_fail   = 0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clock = ~clock;

  function automatic bit golomb_ok(input marks_t a, input int k);
    bit seen[512];
    int d;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    for (int i = 1; i <= k; i++)
      for (int j = 0; j < i; j++) begin
        d = a[i] - a[j];
        if (d <= 0 || d > 511) return 1'b0;
        if (seen[d]) return 1'b0;
        seen[d] = 1'b1;
      end
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NP = (g == 0) ? 3 : 4;
    localparam int MS = (g == 0) ? 2**24 : 16;
    localparam int MW = (NP+1)*9;
    logic [MW-1:0] marks_loc, best_loc;
    int            m_q[8];
    logic [6:0]    nxt_q;
    int            rdy_cnt;

    always_comb begin
      marks_loc = '0;
      for (int i = 0; i <= NP; i++) marks_loc[(NP-i)*9 +: 9] = 9'(m_q[i]);
    end
    assign marks_w[g] = 45'(marks_loc);
    assign best_w[g]  = 45'(best_loc);
    assign nxt_w[g]   = nxt_q;
    assign rdy_w[g]   = (rdy_cnt == 0);

    always @(posedge clock) begin : model
      marks_t tmp;
      int k, nv;
      if (reset) begin
        for (int i = 0; i < 8; i++) m_q[i] <= 0;
        nxt_q   <= 7'd0;
        rdy_cnt <= 0;
      end else if (ctr_reset_w[g]) begin
        for (int i = 0; i < 8; i++) m_q[i] <= 0;
        nxt_q   <= enabled_w[g];
        rdy_cnt <= 3;
      end else begin
        if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
        k = int'(enabled_w[g]);
        if (k >= 1 && k <= NP) begin
          tmp = m_q;
          tmp[k] = tmp[k] + 1;
          if (tmp[k] > int'(limit_w[g])) nv = k - 1;
          else if (golomb_ok(tmp, k)) begin
            nv = k + 1;
            if (k < NP) tmp[k+1] = tmp[k];
          end else nv = k;
          if (g == 0 && abort_mode) nv = 5;
          for (int i = 0; i < 8; i++) m_q[i] <= tmp[i];
          nxt_q <= 7'(nv);
        end
      end
    end

    ruler_search_sequencer #(.NUMPOSITIONS(NP), .MAXVALUE(500), .MAXSTEPS(MS)) dut (
      .clock(clock), .reset(reset), .start(start_w[g]), .pause(pause_w[g]),
      .max_length(maxl_w[g]), .ctr_next_enabled(nxt_w[g]), .ctr_ready(rdy_w[g]),
      .marks_in(marks_loc), .ctr_reset(ctr_reset_w[g]), .enabled(enabled_w[g]),
      .limit(limit_w[g]), .busy(busy_w[g]), .found(found_w[g]), .best_marks(best_loc),
      .best_length(bestlen_w[g]), .done(done_w[g]), .aborted(aborted_w[g]),
      .step_count(stepc_w[g]));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [44:0] pk4(input int a, b, c, d);
    return 45'({9'(a), 9'(b), 9'(c), 9'(d)});
  endfunction

  function automatic logic [44:0] pk5(input int a, b, c, d, e);
    return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e)};
  endfunction

  task automatic push_ev(input int g, input int kind, input logic [44:0] mk, input int len,
                         input bit ab, input int steps);
    ev_t e;
    e.kind = kind; e.marks = mk; e.len = len; e.abrt = ab; e.steps = steps;
    if (g == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pop_ev(input int g, output ev_t e, output bit ok);
    ok = 1'b1;
    e.kind = -1; e.marks = '0; e.len = 0; e.abrt = 1'b0; e.steps = 0;
    if (g == 0) begin
      if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
    end else begin
      if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
    end
  endtask

  // Monitor: pops the scoreboard on each found pulse and each rising done.
  bit         pend[2];
  bit         done_prev[2];
  logic [6:0] en_prev[2];
  int         stepcnt[2];

  initial begin : monitor
    ev_t e;
    bit ok;
    for (int g = 0; g < 2; g++) begin
      pend[g] = 0; done_prev[g] = 0; en_prev[g] = 7'h7F; stepcnt[g] = 0;
    end
    forever begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          pend[g] = 0; done_prev[g] = 0; en_prev[g] = 7'h7F; stepcnt[g] = 0;
        end else begin
          if (pend[g]) begin
            pend[g] = 0;
            pop_ev(g, e, ok);
            chk("found_expected", {63'd0, ok}, 64'd1);
            chk("found_kind", 64'(e.kind), 64'd0);
            chk("best_marks", 64'(best_w[g]), 64'(e.marks));
            chk("best_length", 64'(bestlen_w[g]), 64'(e.len));
          end
          if (found_w[g]) pend[g] = 1;
          if (ctr_reset_w[g]) stepcnt[g] = 0;
          else if (enabled_w[g] != 7'h7F) stepcnt[g]++;
          if (enabled_w[g] != 7'h7F) chk("enabled_not_held", 64'(en_prev[g]), 64'h7F);
          en_prev[g] = enabled_w[g];
          if (done_w[g] && !done_prev[g]) begin
            pop_ev(g, e, ok);
            chk("done_expected", {63'd0, ok}, 64'd1);
            chk("done_kind", 64'(e.kind), 64'd1);
            chk("done_aborted", 64'(aborted_w[g]), 64'(e.abrt));
            chk("done_best_length", 64'(bestlen_w[g]), 64'(e.len));
            chk("done_step_count", 64'(stepc_w[g]),
                (e.steps < 0) ? 64'(stepcnt[g]) : 64'(e.steps));
            chk("done_enabled", 64'(enabled_w[g]), 64'h7F);
            chk("done_busy", 64'(busy_w[g]), 64'd0);
          end
          done_prev[g] = done_w[g];
        end
      end
    end
  end

  task automatic start_run(input int g, input int ml);
    @(negedge clock);
    start_w[g] = 1'b1;
    maxl_w[g]  = 9'(ml);
    @(negedge clock);
    start_w[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done_w[g]) break;
    end
    chk("done_reached", 64'(done_w[g]), 64'd1);
    @(negedge clock);
  endtask

  task automatic wait_step(input int g, input int n, input int budget);
    int c = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (enabled_w[g] != 7'h7F && !ctr_reset_w[g]) c++;
      if (c == n) break;
    end
    chk("step_reached", 64'(c), 64'(n));
  endtask

  task automatic check_reset_vals(input int g);
    chk("rst_ctr_reset", 64'(ctr_reset_w[g]), 64'd0);
    chk("rst_enabled", 64'(enabled_w[g]), 64'h7F);
    chk("rst_limit", 64'(limit_w[g]), 64'd0);
    chk("rst_busy", 64'(busy_w[g]), 64'd0);
    chk("rst_found", 64'(found_w[g]), 64'd0);
    chk("rst_best_marks", 64'(best_w[g]), 64'd0);
    chk("rst_best_length", 64'(bestlen_w[g]), 64'd0);
    chk("rst_done", 64'(done_w[g]), 64'd0);
    chk("rst_aborted", 64'(aborted_w[g]), 64'd0);
    chk("rst_step_count", 64'(stepc_w[g]), 64'd0);
  endtask

  task automatic push_n3_full(input int steps);
    push_ev(0, 0, pk4(0, 1, 3, 7), 7, 1'b0, 0);
    push_ev(0, 0, pk4(0, 1, 4, 6), 6, 1'b0, 0);
    push_ev(0, 1, '0, 6, 1'b0, steps);
  endtask

  initial begin : stimulus
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

    // Too short for 4 marks (needs 6): straight to DONE, nothing found.
    push_ev(0, 1, '0, 0, 1'b0, 0);
    start_run(0, 5);
    wait_done(0, 20);

    // Full search N=3 from limit 10: 11 steps, ends on the optimal length 6.
    push_n3_full(11);
    start_run(0, 10);
    wait_done(0, 500);
    chk("limit_after_optimal", 64'(limit_w[0]), 64'd5);

    // Pause while holding COLLECT after the third step.
    push_n3_full(11);
    start_run(0, 10);
    wait_step(0, 3, 200);
    pause_w[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("pause_enabled", 64'(enabled_w[0]), 64'h7F);
      chk("pause_step_count", 64'(stepc_w[0]), 64'd3);
    end
    pause_w[0] = 1'b0;
    wait_done(0, 500);

    // Counter reports level 5 with N=3: protocol error two cycles after STEP.
    abort_mode = 1'b1;
    push_ev(0, 1, '0, 0, 1'b1, 1);
    start_run(0, 10);
    wait_step(0, 1, 50);
    @(posedge clock);
    #1 chk("abort_not_yet", 64'(done_w[0]), 64'd0);
    @(posedge clock);
    #1;
    chk("abort_done", 64'(done_w[0]), 64'd1);
    chk("abort_flag", 64'(aborted_w[0]), 64'd1);
    wait_done(0, 10);
    abort_mode = 1'b0;

    // Reset during COLLECT after step 5, then rerun to the same result.
    start_run(0, 10);
    wait_step(0, 5, 200);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check_reset_vals(0);
    push_n3_full(11);
    start_run(0, 10);
    wait_done(0, 500);

    // Step budget of 16 with N=4: one ruler {0,1,3,7,12} then abort.
    push_ev(1, 0, pk5(0, 1, 3, 7, 12), 12, 1'b0, 0);
    push_ev(1, 1, '0, 12, 1'b1, 16);
    start_run(1, 200);
    wait_done(1, 500);
    chk("budget_limit", 64'(limit_w[1]), 64'd11);
    chk("budget_enabled", 64'(enabled_w[1]), 64'h7F);

    repeat (3) @(negedge clock);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
